// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
//   Generic one-stage pipeline buffer with valid/ready flow control, a
//   synchronous flush and an optional second (skid) entry. It sits between two
//   pipeline stages and carries their PC/instruction/control payload.
//
//   SKID=1: up to two entries. in_ready comes from state only, so there is no
//           combinational path from out_ready to in_ready.
//   SKID=0: one entry. in_ready = !out_valid | out_ready, which still gives
//           back-to-back throughput.
//
// Ports
//   Clk        clock, rising edge
//   Rst        asynchronous active-high reset
//   flush      synchronous flush; drops every held entry, loads RST_VAL
//   in_valid   upstream presents in_data
//   in_ready   stage accepts a payload this cycle
//   in_data    upstream payload, DW bits
//   out_valid  stage presents out_data
//   out_ready  downstream accepts this cycle
//   out_data   payload presented downstream (main register)
//   occ        number of held entries, 0..2
// -----------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int unsigned     DW      = 64,
   parameter logic [DW-1:0]   RST_VAL = {DW{1'b0}},
   parameter int unsigned     SKID    = 1
) (
   input  logic          Clk,
   input  logic          Rst,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    occ
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [DW-1:0] main_q,  main_d;
   logic [DW-1:0] skid_q,  skid_d;
   logic          in_fire;
   logic          out_fire;

   assign in_fire  = in_valid  & in_ready;
   assign out_fire = out_valid & out_ready;
   assign out_data = main_q;

   // State register
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_q <= ST_EMPTY;
         main_q  <= RST_VAL;
         skid_q  <= RST_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   // Next-state and datapath load selection
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         // A payload accepted in this cycle is intentionally discarded.
         state_d = ST_EMPTY;
         main_d  = RST_VAL;
         skid_d  = RST_VAL;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (in_fire) begin
                  state_d = ST_FULL;
                  main_d  = in_data;
               end
            end
            ST_FULL: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (in_fire && (SKID != 0)) begin
                  // Downstream stalled while upstream was still allowed in:
                  // park the newcomer behind main.
                  state_d = ST_SKID;
                  skid_d  = in_data;
               end else if (out_fire) begin
                  // main keeps its old value; out_data is don't-care now.
                  state_d = ST_EMPTY;
               end
            end
            ST_SKID: begin
               if (out_fire) begin
                  state_d = ST_FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Outputs decoded from state (plus out_ready for in_ready when SKID=0)
   always_comb begin
      out_valid = 1'b0;
      occ       = 2'd0;
      case (state_q)
         ST_FULL: begin
            out_valid = 1'b1;
            occ       = 2'd1;
         end
         ST_SKID: begin
            out_valid = 1'b1;
            occ       = 2'd2;
         end
         default: begin
            out_valid = 1'b0;
            occ       = 2'd0;
         end
      endcase
      if (SKID != 0) in_ready = (state_q != ST_SKID);
      else           in_ready = (state_q == ST_EMPTY) | out_ready;
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register. It replaces the fixed 32-bit IF/ID-style latch with a generic one-stage buffer carrying an arbitrary-width payload. The buffer has valid/ready flow control, synchronous flush and an optional 2-entry skid buffer so that `in_ready` is registered. It is instantiated between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB), with the payload being the stage's PC, instruction and control bundle concatenated.

## Interface
Parameters:
- `DW`, default 64: payload width in bits (≥1).
- `RST_VAL`, default `{DW{1'b0}}`: payload value loaded on reset and on flush.
- `SKID`, default 1: 1 = 2-entry skid mode with registered `in_ready`; 0 = single-entry mode with combinational `in_ready`.

Ports:
- `Clk`, input, 1: clock, rising edge.
- `Rst`, input, 1: reset, asynchronous, active-high.
- `flush`, input, 1: synchronous flush; kills every entry held in the stage.
- `in_valid`, input, 1: upstream presents a payload.
- `in_ready`, output, 1: stage accepts a payload this cycle.
- `in_data`, input, DW: upstream payload.
- `out_valid`, output, 1: stage presents a payload downstream.
- `out_ready`, input, 1: downstream accepts this cycle.
- `out_data`, output, DW: payload presented downstream.
- `occ`, output, 2: number of entries held (0..2; max 1 when SKID=0).

## Operation
- Handshakes:
  - in_fire = `in_valid & in_ready`.
  - out_fire = `out_valid & out_ready`.
  - A payload transfers only on a fire.
  - `in_valid` and `in_data` must stay stable until accepted; `out_valid` and `out_data` are held stable until `out_ready`.
- Storage: `main` register drives `out_data`. `skid` register (SKID=1 only) holds a second entry.
- States (SKID=1), with `in_ready` decoded from state only (no combinational path from `out_ready`):
  - EMPTY: `out_valid`=0, `in_ready`=1, `occ`=0.
  - FULL: `out_valid`=1, `in_ready`=1, `occ`=1.
  - SKID: `out_valid`=1, `in_ready`=0, `occ`=2.
- Transitions (when `flush`=0):
  - EMPTY: in_fire → FULL, main←in_data.
  - FULL: in_fire & out_fire → FULL, main←in_data.
  - FULL: in_fire & !out_fire → SKID, skid←in_data.
  - FULL: !in_fire & out_fire → EMPTY.
  - FULL: neither fires → hold.
  - SKID: out_fire → FULL, main←skid.
  - SKID: no out_fire → hold.
- SKID=0:
  - States EMPTY and FULL only.
  - `in_ready` = `!out_valid | out_ready` (combinational).
  - FULL with in_fire & out_fire → FULL, main replaced (back-to-back throughput, 1 payload/cycle).
- Flush:
  - Highest priority below `Rst`.
  - Next state EMPTY; main and skid ← `RST_VAL`.
  - An in_fire in the flush cycle is a completed handshake upstream, but its payload is discarded.
  - An out_fire in the flush cycle is valid; downstream consumes the payload presented that cycle.
- Drain to EMPTY without flush: `main` keeps its last value; `out_data` is don't-care while `out_valid`=0.
- Ordering: strict FIFO; the skid entry is never presented before main.

## Timing
- Reset values: `out_valid`=0, `out_data`=`RST_VAL`, `occ`=0. `in_ready`=1 in both modes.
- Latency: in_fire at edge N → `out_valid`=1 with that payload after edge N (visible cycle N+1). No same-cycle bypass.
- Throughput: 1 payload/cycle while `out_ready`=1, in both modes.
- SKID=1 backpressure:
  - `out_ready` deasserted in cycle N causes `in_ready`=0 from cycle N+1.
  - The one payload accepted in cycle N lands in skid.
  - `in_ready` returns to 1 the cycle after the first out_fire in SKID.
- `Rst` mid-transfer: all entries dropped immediately (asynchronous); no partial state survives.
- `flush` held multiple cycles: stage stays EMPTY; `in_ready` stays 1 and all accepted payloads are dropped.

## Test plan
- Reset, then stream 0x1..0x8 (DW=64) with `out_ready`=1 continuously → `out_data` 0x1..0x8 on consecutive cycles, one cycle after each accept; `occ`=1 throughout.
- SKID=1: FULL with 0xA, present 0xB, drop `out_ready` for 3 cycles → 0xB captured in skid, `occ`=2, `in_ready`=0 for 3 cycles. Raise `out_ready` → out 0xA then 0xB; `in_ready`=1 one cycle after 0xA leaves.
- SKID state, assert `flush` with `in_valid`=1 → next cycle `occ`=0, `out_valid`=0, `out_data`=`RST_VAL`; the flush-cycle payload never appears at the output.
- SKID=0, FULL, `out_ready`=0 → `in_ready`=0 in the same cycle. `out_ready`=1 with `in_valid`=1 → main replaced on that edge, no bubble.
- Assert `Rst` asynchronously mid-stream, off a clock edge → `out_valid`=0 and `occ`=0 before the next edge; after release, the first accepted payload appears one cycle later.
- Random `in_valid`/`out_ready` (10k cycles, both SKID values, with random flush) → scoreboard shows in-order, no duplication, and loss only of entries held at flush or accepted in the flush cycle.
